// File: rtl/hold_study_bd.sv
// Hold-time study harness: registers din into the flop under study and timestamps
// din rise (capture) and fall edges to report the margin between them.
module hold_study_bd #(
  parameter int TW = 32,
  parameter int CW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            din,
  input  logic [CW-1:0]   capa_charge_val,
  input  logic [CW-1:0]   tt_val_clk,
  input  logic [CW-1:0]   tt_val_d,
  input  logic            fin_test,
  output logic            dout,
  output logic [TW-1:0]   clk_rise_time,
  output logic [TW-1:0]   d_fall_time,
  output logic [TW-1:0]   hold_margin,
  output logic            meas_valid,
  output logic [15:0]     meas_count,
  output logic [TW-1:0]   min_margin,
  output logic [3*CW-1:0] cfg_snap,
  output logic            done
);

  logic [TW-1:0] ts;
  logic          din_d;
  logic          armed;
  logic          capture;
  logic          fall;
  logic          measure;
  logic [TW-1:0] margin_new;

  // done is registered, so a fall in the cycle fin_test first rises still measures
  always_comb begin
    capture    = !done && !din_d && din;
    fall       = !done && din_d && !din;
    measure    = fall && armed;
    margin_new = ts - clk_rise_time;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ts            <= '0;
      dout          <= 1'b0;
      din_d         <= 1'b0;
      clk_rise_time <= '0;
      d_fall_time   <= '0;
      hold_margin   <= '0;
      meas_valid    <= 1'b0;
      meas_count    <= '0;
      min_margin    <= '1;
      cfg_snap      <= '0;
      armed         <= 1'b0;
      done          <= 1'b0;
    end else begin
      ts         <= ts + TW'(1);
      dout       <= din;
      din_d      <= din;
      meas_valid <= measure;
      if (capture) begin
        clk_rise_time <= ts;
        cfg_snap      <= {capa_charge_val, tt_val_clk, tt_val_d};
        armed         <= 1'b1;
      end
      if (fall) begin
        d_fall_time <= ts;
      end
      if (measure) begin
        hold_margin <= margin_new;
        armed       <= 1'b0;
        if (meas_count != 16'hFFFF) begin
          meas_count <= meas_count + 16'd1;
        end
        if (margin_new < min_margin) begin
          min_margin <= margin_new;
        end
      end
      if (fin_test) begin
        done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hold_study_bd.sv
// Bench for hold_study_bd (8-bit timestamps to reach the wrap quickly): directed
// scenarios plus random din/fin_test/rst traffic against a cycle-level reference model.
module tb_hold_study_bd;
  localparam int TW = 8;
  localparam int CW = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            din = 1'b0;
  logic [CW-1:0]   capa_charge_val = '0;
  logic [CW-1:0]   tt_val_clk = '0;
  logic [CW-1:0]   tt_val_d = '0;
  logic            fin_test = 1'b0;
  logic            dout;
  logic [TW-1:0]   clk_rise_time;
  logic [TW-1:0]   d_fall_time;
  logic [TW-1:0]   hold_margin;
  logic            meas_valid;
  logic [15:0]     meas_count;
  logic [TW-1:0]   min_margin;
  logic [3*CW-1:0] cfg_snap;
  logic            done;

  int n_vec = 0;
  int n_bad = 0;

  // reference model state
  int              m_ts, m_rise, m_fall, m_margin, m_cnt, m_min;
  bit              m_prev, m_armed, m_valid, m_done, m_dout;
  logic [3*CW-1:0] m_cfg;

  hold_study_bd #(.TW(TW), .CW(CW)) dut (
    .clk(clk), .rst(rst), .din(din),
    .capa_charge_val(capa_charge_val), .tt_val_clk(tt_val_clk), .tt_val_d(tt_val_d),
    .fin_test(fin_test), .dout(dout), .clk_rise_time(clk_rise_time),
    .d_fall_time(d_fall_time), .hold_margin(hold_margin), .meas_valid(meas_valid),
    .meas_count(meas_count), .min_margin(min_margin), .cfg_snap(cfg_snap), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Applies the behavioural rules to the inputs seen at this edge.
  task automatic model_edge();
    if (rst) begin
      m_ts = 0; m_rise = 0; m_fall = 0; m_margin = 0; m_cnt = 0; m_min = 255;
      m_prev = 0; m_armed = 0; m_valid = 0; m_done = 0; m_dout = 0; m_cfg = '0;
    end else begin
      m_valid = 0;
      if (!m_done && !m_prev && din) begin
        m_rise  = m_ts;
        m_cfg   = {capa_charge_val, tt_val_clk, tt_val_d};
        m_armed = 1;
      end
      if (!m_done && m_prev && !din) begin
        m_fall = m_ts;
        if (m_armed) begin
          m_margin = (m_ts - m_rise + 256) % 256;
          m_valid  = 1;
          if (m_cnt < 65535) m_cnt++;
          if (m_margin < m_min) m_min = m_margin;
          m_armed = 0;
        end
      end
      if (fin_test) m_done = 1;
      m_dout = din;
      m_prev = din;
      m_ts   = (m_ts + 1) % 256;
    end
  endtask

  task automatic check_all();
    chk("dout", 64'(dout), 64'(m_dout));
    chk("clk_rise_time", 64'(clk_rise_time), 64'(m_rise));
    chk("d_fall_time", 64'(d_fall_time), 64'(m_fall));
    chk("hold_margin", 64'(hold_margin), 64'(m_margin));
    chk("meas_valid", 64'(meas_valid), 64'(m_valid));
    chk("meas_count", 64'(meas_count), 64'(m_cnt));
    chk("min_margin", 64'(min_margin), 64'(m_min));
    chk("cfg_snap", 64'(cfg_snap), 64'(m_cfg));
    chk("done", 64'(done), 64'(m_done));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic run(input int n, input bit d);
    din = d;
    repeat (n) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic rand_cfg();
    capa_charge_val = CW'($urandom);
    tt_val_clk      = CW'($urandom);
    tt_val_d        = CW'($urandom);
  endtask

  initial begin
    logic [3*CW-1:0] cfg2;

    // reset state and idle din
    do_reset();
    chk("rst_min_margin", 64'(min_margin), 64'hFF);
    chk("rst_count", 64'(meas_count), 64'd0);
    run(10, 1'b0);
    chk("idle_valid", 64'(meas_valid), 64'd0);
    chk("idle_dout", 64'(dout), 64'd0);
    chk("idle_min", 64'(min_margin), 64'hFF);

    // rise at ts=5, fall at ts=12
    do_reset();
    run(5, 1'b0);
    run(7, 1'b1);
    run(1, 1'b0);
    chk("basic_rise", 64'(clk_rise_time), 64'd5);
    chk("basic_fall", 64'(d_fall_time), 64'd12);
    chk("basic_margin", 64'(hold_margin), 64'd7);
    chk("basic_valid", 64'(meas_valid), 64'd1);
    chk("basic_count", 64'(meas_count), 64'd1);
    run(1, 1'b0);
    chk("basic_pulse_end", 64'(meas_valid), 64'd0);

    // widths 7 then 3; snapshot taken at second rise only
    do_reset();
    rand_cfg();
    run(3, 1'b0);
    run(7, 1'b1);
    run(2, 1'b0);
    rand_cfg();
    cfg2 = {capa_charge_val, tt_val_clk, tt_val_d};
    run(1, 1'b1);
    rand_cfg();
    run(2, 1'b1);
    run(2, 1'b0);
    chk("two_min", 64'(min_margin), 64'd3);
    chk("two_count", 64'(meas_count), 64'd2);
    chk("two_cfg", 64'(cfg_snap), 64'(cfg2));

    // din high across reset: reset drops the armed pulse, release re-samples
    run(3, 1'b1);
    do_reset();
    run(4, 1'b1);
    run(2, 1'b0);

    // timestamp wrap
    do_reset();
    run(254, 1'b0);
    run(4, 1'b1);
    run(1, 1'b0);
    chk("wrap_rise", 64'(clk_rise_time), 64'd254);
    chk("wrap_fall", 64'(d_fall_time), 64'd2);
    chk("wrap_margin", 64'(hold_margin), 64'd4);

    // fin_test blocks later pulses
    do_reset();
    fin_test = 1'b1;
    run(1, 1'b0);
    fin_test = 1'b0;
    run(3, 1'b1);
    run(2, 1'b0);
    chk("fin_done", 64'(done), 64'd1);
    chk("fin_count", 64'(meas_count), 64'd0);
    chk("fin_fall_blocked", 64'(d_fall_time), 64'd0);

    // fall coincident with fin_test still measures
    do_reset();
    run(2, 1'b1);
    fin_test = 1'b1;
    run(1, 1'b0);
    fin_test = 1'b0;
    run(1, 1'b0);
    chk("fin_same_count", 64'(meas_count), 64'd1);
    chk("fin_same_done", 64'(done), 64'd1);
    do_reset();
    chk("fin_clr_done", 64'(done), 64'd0);
    chk("fin_clr_count", 64'(meas_count), 64'd0);

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 3) == 0) din = ~din;
      rand_cfg();
      fin_test = ($urandom_range(0, 599) == 0);
      rst      = ($urandom_range(0, 349) == 0);
      tick();
    end
    rst = 1'b0;
    fin_test = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
